// File: rtl/if_next_pc_unit.sv
// Instruction-fetch next-PC selection and IF/ID pipeline register.
// Handles stalls, flushes wrong-path fetches on redirect, and latches a redirect seen during a stall.
module if_next_pc_unit #(
  parameter int unsigned     B            = 32,
  parameter int unsigned     INSTR_W      = 32,
  parameter logic [B-1:0]    RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [B-1:0]       pc_in,
  output logic [B-1:0]       next_out,
  input  logic [INSTR_W-1:0] imem_instr_i,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [B-1:0]       branch_target_i,
  input  logic               jump_i,
  input  logic [B-1:0]       jump_target_i,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [B-1:0]       ifid_pc_plus4_o,
  output logic               ifid_valid_o,
  output logic               redirect_pending_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [B-1:0]       r_pend_tgt;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [B-1:0]       r_ifid_pc4;
  logic               r_ifid_valid;
  logic               r_redirect_pending;

  logic [B-1:0]       w_pc_plus4;
  logic [B-1:0]       w_tgt;
  logic               w_redirect;
  logic [B-1:0]       w_next_pc;
  logic               w_ifid_load;
  logic               w_ifid_flush;
  logic               w_pend_load;

  // Branch wins over jump because it belongs to the older instruction.
  assign w_pc_plus4 = pc_in + B'(4);
  assign w_redirect = branch_taken_i | jump_i;
  assign w_tgt      = branch_taken_i ? {branch_target_i[B-1:2], 2'b00}
                                     : {jump_target_i[B-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = pc_in;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_pend_load  = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_next_pc    = RESET_VECTOR;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_redirect && stall_i) begin
          w_pend_load  = 1'b1;
          w_next_state = S_PEND;
        end else if (w_redirect) begin
          w_next_pc    = w_tgt;
          w_ifid_flush = 1'b1;
        end else if (!stall_i) begin
          w_next_pc    = w_pc_plus4;
          w_ifid_load  = 1'b1;
        end
      end
      S_PEND: begin
        if (stall_i) begin
          w_pend_load  = w_redirect;
        end else begin
          w_next_pc    = w_redirect ? w_tgt : r_pend_tgt;
          w_ifid_flush = 1'b1;
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_pc    = RESET_VECTOR;
        w_next_state = S_BOOT;
      end
    endcase
  end

  assign next_out = rst_n ? w_next_pc : RESET_VECTOR;

  // IF/ID register, pending target and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_instr       <= '0;
      r_ifid_pc4         <= '0;
      r_ifid_valid       <= 1'b0;
      r_pend_tgt         <= '0;
      r_redirect_pending <= 1'b0;
    end else begin
      if (w_ifid_flush) begin
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
        r_ifid_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_ifid_instr <= imem_instr_i;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
      if (w_pend_load) begin
        r_pend_tgt <= w_tgt;
      end
      r_redirect_pending <= (w_next_state == S_PEND);
    end
  end

  assign ifid_instr_o       = r_ifid_instr;
  assign ifid_pc_plus4_o    = r_ifid_pc4;
  assign ifid_valid_o       = r_ifid_valid;
  assign redirect_pending_o = r_redirect_pending;

endmodule
